// File: rtl/dot_mac_pipe.sv
// dot_mac_pipe: pipelined multi-lane signed dot-product accumulator.
//
// Each accepted beat multiplies LANES signed operand pairs. The products are
// summed, and the sum is accumulated across beats. A beat flagged in_last
// closes the transaction. Its result is then presented on a valid/ready
// output, clamped when SAT=1 and wrapped when SAT=0.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_last             final beat of the current dot product
//   a_vec, b_vec        LANES packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready result handshake
//   out_data            signed dot-product result (ACC_W bits)
//   out_sat             overflow occurred somewhere in this result's transaction
//
// Pipeline:
//   stage 1 registers the per-lane products.
//   stage 2 reduces the products, adds the sum to the accumulator, and
//   either updates the accumulator or emits the result.
// The whole pipeline freezes while a result is held by backpressure.

module dot_mac_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int LANES  = 4,
    parameter int SAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [LANES*DATA_W-1:0]   a_vec,
    input  logic [LANES*DATA_W-1:0]   b_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      out_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    // Wide enough that neither the accumulator nor the lane sum can overflow
    // the addition itself. Overflow is then judged against ACC_W.
    localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q,  s1_last_d;
    logic signed [ACC_W-1:0]  acc_q,      acc_d;
    logic                     sticky_q,   sticky_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0]  out_data_q,  out_data_d;
    logic                     out_sat_q,   out_sat_d;

    logic                     stall;
    logic                     accept;
    logic signed [SUM_W-1:0]  lane_sum;
    logic signed [WIDE_W-1:0] next_w;
    logic                     ovf;
    logic signed [ACC_W-1:0]  result;

    // Lane reduction. It is written as a linear sum; synthesis balances it into a tree.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(prod_q[i]);
        end
        next_w = WIDE_W'(acc_q) + WIDE_W'(lane_sum);
        ovf    = (next_w > WIDE_W'(ACC_MAX)) || (next_w < WIDE_W'(ACC_MIN));
        if (ovf && (SAT != 0)) begin
            result = next_w[WIDE_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            result = next_w[ACC_W-1:0];
        end
    end

    always_comb begin
        stall    = out_valid_q && !out_ready;
        in_ready = !stall;
        accept   = in_valid && in_ready;

        prod_d      = prod_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (!stall) begin
            s1_valid_d = accept;
            s1_last_d  = accept && in_last;
            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_d[i] = PROD_W'($signed(a_vec[i*DATA_W +: DATA_W])) *
                                PROD_W'($signed(b_vec[i*DATA_W +: DATA_W]));
                end
            end

            // Not stalled, so a valid output is being consumed on this edge.
            if (out_valid_q) begin
                out_valid_d = 1'b0;
            end

            if (s1_valid_q) begin
                if (s1_last_q) begin
                    // A new result overrides the consumed one on the same edge.
                    out_valid_d = 1'b1;
                    out_data_d  = result;
                    out_sat_d   = sticky_q || ovf;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                end else begin
                    acc_d    = result;
                    sticky_d = sticky_q || ovf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dot_mac_pipe.sv
// tb_dot_mac_pipe: directed self-checking bench for dot_mac_pipe.
// Instances:
//   dut    default parameters (32-bit accumulator, saturating)
//   dut_s  16-bit accumulator, saturating
//   dut_w  16-bit accumulator, wrapping
// All three instances share the same stimulus.

module tb_dot_mac_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] a_vec;
    logic [31:0] b_vec;

    logic        in_ready,  out_valid,  out_sat;
    logic [31:0] out_data;
    logic        s_in_ready, s_out_valid, s_out_sat;
    logic [15:0] s_out_data;
    logic        w_in_ready, w_out_valid, w_out_sat;
    logic [15:0] w_out_data;

    int n_chk  = 0;
    int n_pass = 0;
    bit rec    = 1'b0;
    longint got_q[$];
    longint exp_q[$];

    always #5 clk = ~clk;

    dot_mac_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    dot_mac_pipe #(.ACC_W(16), .SAT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_sat(s_out_sat)
    );

    dot_mac_pipe #(.ACC_W(16), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_data(w_out_data), .out_sat(w_out_sat)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rec && out_valid && out_ready) got_q.push_back(longint'($signed(out_data)));
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_last  = l;
        a_vec    = a;
        b_vec    = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ones, p127, pm128;
        ones  = pack4(1, 1, 1, 1);
        p127  = pack4(127, 127, 127, 127);
        pm128 = pack4(-128, -128, -128, -128);

        // Reset state
        do_reset();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single beat {1,2,3,4}x{5,6,7,8} = 70
        drive(1, 1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        step();
        drive(0, 0, '0, '0);
        chk("t1_lat_valid", out_valid, 0);
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", longint'($signed(out_data)), 70);
        chk("t1_sat", out_sat, 0);
        step();
        chk("t1_clear", out_valid, 0);

        // Three beats of -1x2, then a back-to-back {1}x{1} transaction
        drive(1, 0, pack4(-1, -1, -1, -1), pack4(2, 2, 2, 2));
        step();
        step();
        drive(1, 1, pack4(-1, -1, -1, -1), pack4(2, 2, 2, 2));
        step();
        drive(1, 1, ones, ones);
        step();
        drive(0, 0, '0, '0);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", longint'($signed(out_data)), -24);
        step();
        chk("t2b_valid", out_valid, 1);
        chk("t2b_data", longint'($signed(out_data)), 4);
        step();
        chk("t2b_clear", out_valid, 0);

        // Overflow: 127*127*4 = 64516 in one beat
        do_reset();
        drive(1, 1, p127, p127);
        step();
        drive(0, 0, '0, '0);
        step();
        chk("sat_data", longint'($signed(s_out_data)), 32767);
        chk("sat_flag", s_out_sat, 1);
        chk("wrap_data", longint'($signed(w_out_data)), -1020);
        chk("wrap_flag", w_out_sat, 1);
        chk("wide_data", longint'($signed(out_data)), 64516);
        chk("wide_flag", out_sat, 0);

        // Accumulate from the clamped value; sticky flag persists
        drive(1, 0, p127, p127);
        step();
        drive(1, 1, pack4(-1, 0, 0, 0), pack4(1, 0, 0, 0));
        step();
        drive(0, 0, '0, '0);
        step();
        chk("sat2_data", longint'($signed(s_out_data)), 32766);
        chk("sat2_flag", s_out_sat, 1);
        chk("wrap2_data", longint'($signed(w_out_data)), -1021);
        chk("wrap2_flag", w_out_sat, 1);
        chk("wide2_data", longint'($signed(out_data)), 64515);

        // Negative overflow: -128*127*4 = -65024
        drive(1, 1, pm128, p127);
        step();
        drive(0, 0, '0, '0);
        step();
        chk("satn_data", longint'($signed(s_out_data)), -32768);
        chk("satn_flag", s_out_sat, 1);
        chk("wrapn_data", longint'($signed(w_out_data)), 512);
        chk("widen_data", longint'($signed(out_data)), -65024);

        // The sticky flag must not leak into the next transaction
        drive(1, 1, pack4(1, 0, 0, 0), pack4(1, 0, 0, 0));
        step();
        drive(0, 0, '0, '0);
        step();
        chk("satc_data", longint'($signed(s_out_data)), 1);
        chk("satc_flag", s_out_sat, 0);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        drive(1, 1, pack4(2, 0, 0, 0), pack4(3, 0, 0, 0));
        step();
        drive(1, 1, ones, ones);
        step();
        chk("bp_valid", out_valid, 1);
        chk("bp_data", longint'($signed(out_data)), 6);
        chk("bp_in_ready", in_ready, 0);
        drive(1, 1, pack4(1, 0, 0, 0), pack4(7, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_data", longint'($signed(out_data)), 6);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        drive(0, 0, '0, '0);
        chk("bp_rel_valid", out_valid, 1);
        chk("bp_rel_data", longint'($signed(out_data)), 4);
        chk("bp_rel_ready", in_ready, 1);
        step();
        chk("bp_c_data", longint'($signed(out_data)), 7);
        chk("bp_c_valid", out_valid, 1);
        step();
        chk("bp_drain", out_valid, 0);

        // Two 8-beat transactions with random input gaps
        do_reset();
        step();
        got_q.delete();
        exp_q.delete();
        rec = 1'b1;
        for (int t = 0; t < 2; t++) begin
            int acc_m;
            acc_m = 0;
            for (int k = 0; k < 8; k++) begin
                int av[4];
                int bv[4];
                while ($urandom_range(0, 1) == 0) begin
                    drive(0, 0, '0, '0);
                    step();
                end
                for (int i = 0; i < 4; i++) begin
                    av[i] = ((k + 8 * t) * 3 + i) % 11 - 5;
                    bv[i] = ((k + 8 * t) + 2 * i) % 7 - 3;
                    acc_m += av[i] * bv[i];
                end
                drive(1, k == 7, pack4(av[0], av[1], av[2], av[3]), pack4(bv[0], bv[1], bv[2], bv[3]));
                step();
            end
            exp_q.push_back(longint'(acc_m));
        end
        drive(0, 0, '0, '0);
        repeat (4) step();
        rec = 1'b0;
        chk("rnd_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("rnd_data", (i < got_q.size()) ? got_q[i] : 64'sd99999, exp_q[i]);
        end

        // Reset in the middle of a transaction
        drive(1, 0, ones, ones);
        step();
        step();
        drive(0, 0, '0, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_sat", out_sat, 0);
        chk("mid_rst_ready", in_ready, 1);
        drive(1, 1, pack4(1, 0, 0, 0), pack4(9, 0, 0, 0));
        step();
        drive(0, 0, '0, '0);
        step();
        chk("mid_rst_new_valid", out_valid, 1);
        chk("mid_rst_new_data", longint'($signed(out_data)), 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
